seq_shifter: RTL

Multi-cycle iterative shifter that performs one single-bit shift per clock, the sequential counterpart to the combinational shift-operator blocks. A requester presents an operand, an opcode and a shift amount with a one-cycle `start` pulse. The block shifts the operand one position per cycle, then returns the result with a one-cycle `done` pulse. It sits behind any controller that needs shifts without a full barrel shifter.

---
 rtl/seq_shifter.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Iterative shifter: one single-bit LSL/LSR/ASR/ROL step per clock.
// Result is registered on entry to DONE and held until the next completion.
module seq_shifter #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] work_step;
  logic             accept;
  logic             last_step;

  function automatic logic [WIDTH-1:0] step1(input logic [1:0] o,
                                             input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    case (o)
      OP_LSL:  r = {w[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, w[WIDTH-1:1]};
      OP_ASR:  r = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROL:  r = {w[WIDTH-2:0], w[WIDTH-1]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign work_step = step1(op_q, work);
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == AMT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (amt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == AMT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure state decodes, so they never see input glitches
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      op_q <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      if (accept) begin
        work <= din;
        op_q <= op;
        cnt  <= amt;
        if (amt == '0) dout <= din;
      end else if (state == SHIFT) begin
        work <= work_step;
        cnt  <= cnt - AMT_W'(1);
        // dout takes the final step result on the edge entering DONE
        if (last_step) dout <= work_step;
      end
    end
  end

endmodule
